// File: rtl/cart_scheme_detect_if.sv
// HPS ioctl download stream as seen by the cartridge scheme detector.
interface cart_scheme_detect_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
  modport slave  (input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/cart_scheme_detect.sv
// Sniffs the ROM download stream and classifies bank-switching scheme,
// SuperChip enable and image size once the download completes.
//
// state  | meaning
// IDLE   | no image seen since reset
// LOAD   | download active, counting bytes and signature hits
// DECIDE | one cycle: register scheme, sc and size
// DONE   | results valid, waiting for next download
module cart_scheme_detect #(
  parameter int SIG_3F_MIN  = 2,
  parameter int SC_FILL_LEN = 256
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  cart_scheme_detect_if.slave        ioctl,
  input  logic [23:0]                file_ext,
  input  logic [1:0]                 sc_mode,
  output logic [3:0]                 force_bs,
  output logic                       sc,
  output logic [16:0]                rom_size,
  output logic                       detect_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state;
  logic        dl_q;
  logic [16:0] cnt;
  logic [39:0] sh;
  logic [7:0]  cnt_e0, cnt_3f, cnt_fe, first_byte;
  logic        fill_ok;
  logic [23:0] ext_q;
  logic [1:0]  mode_q;

  logic        rise, fall, start, take;
  logic [39:0] shifted;
  logic        hit_e0, hit_3f, hit_fe;

  logic [16:0] cnt_b, cnt_n;
  logic [39:0] sh_b, sh_n;
  logic [7:0]  e0_b, e0_n, f3_b, f3_n, fe_b, fe_n, first_b, first_n, first_eff;
  logic        fill_b, fill_n;
  logic [3:0]  bs_dec;
  logic        sc_dec;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic hit);
    return (hit && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  assign rise  = ioctl.ioctl_download & ~dl_q;
  assign fall  = ~ioctl.ioctl_download & dl_q;
  assign start = rise && (state == S_IDLE || state == S_DONE);
  // The byte strobed with the rising edge belongs to the new image; the one
  // strobed with the falling edge does not.
  assign take  = ioctl.ioctl_wr && (start || (state == S_LOAD && !fall));

  assign shifted = {sh_b[31:0], ioctl.ioctl_dout};
  assign hit_e0  = (shifted[23:16] == 8'h8D || shifted[23:16] == 8'hAD || shifted[23:16] == 8'h2C)
                 && shifted[15:11] == 5'b11100
                 && (shifted[7:0] == 8'h1F || shifted[7:0] == 8'hFF);
  assign hit_3f  = shifted[15:0] == 16'h853F;
  assign hit_fe  = shifted == 40'h20_00_D0_C6_C5;

  always_comb begin
    cnt_b   = start ? '0 : cnt;
    sh_b    = start ? '0 : sh;
    e0_b    = start ? '0 : cnt_e0;
    f3_b    = start ? '0 : cnt_3f;
    fe_b    = start ? '0 : cnt_fe;
    first_b = start ? '0 : first_byte;
    fill_b  = start ? 1'b1 : fill_ok;
    cnt_n   = cnt_b;
    sh_n    = sh_b;
    e0_n    = e0_b;
    f3_n    = f3_b;
    fe_n    = fe_b;
    first_n = first_b;
    fill_n  = fill_b;
    first_eff = (ioctl.ioctl_addr == '0) ? ioctl.ioctl_dout : first_b;
    if (take) begin
      cnt_n = (&cnt_b) ? cnt_b : cnt_b + 17'd1;
      sh_n  = shifted;
      e0_n  = sat_inc(e0_b, hit_e0);
      f3_n  = sat_inc(f3_b, hit_3f);
      fe_n  = sat_inc(fe_b, hit_fe);
      if (ioctl.ioctl_addr == '0) first_n = ioctl.ioctl_dout;
      if (ioctl.ioctl_addr < 25'(SC_FILL_LEN) && ioctl.ioctl_dout != first_eff) fill_n = 1'b0;
    end
  end

  // Lowest priority first so later assignments win.
  always_comb begin
    bs_dec = 4'd0;
    if (cnt == 17'd8192)                          bs_dec = 4'd1;
    else if (cnt == 17'd12288)                    bs_dec = 4'd8;
    else if (cnt == 17'd16384)                    bs_dec = 4'd2;
    else if (cnt == 17'd32768)                    bs_dec = 4'd6;
    else if (cnt >= 17'd10240 && cnt <= 17'd10495) bs_dec = 4'd7;
    if (cnt_fe != 8'd0 && cnt == 17'd8192)        bs_dec = 4'd3;
    if (cnt_e0 != 8'd0 && cnt == 17'd8192)        bs_dec = 4'd4;
    if (cnt_3f >= 8'(SIG_3F_MIN) && cnt > 17'd4096) bs_dec = 4'd5;
    case (ext_q)
      ".F8":   bs_dec = 4'd1;
      ".F6":   bs_dec = 4'd2;
      ".FE":   bs_dec = 4'd3;
      ".E0":   bs_dec = 4'd4;
      ".3F":   bs_dec = 4'd5;
      ".F4":   bs_dec = 4'd6;
      ".P2":   bs_dec = 4'd7;
      ".FA":   bs_dec = 4'd8;
      ".CV":   bs_dec = 4'd9;
      default: ;
    endcase
  end

  always_comb begin
    case (mode_q)
      2'd1:    sc_dec = 1'b0;
      2'd2,
      2'd3:    sc_dec = 1'b1;
      default: sc_dec = (ext_q[7:0] == 8'h53) || (fill_ok && cnt >= 17'd8192);
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      // Track the live level so a download already in flight is not
      // mistaken for a fresh rising edge once reset lifts.
      dl_q        <= ioctl.ioctl_download;
      cnt         <= '0;
      sh          <= '0;
      cnt_e0      <= '0;
      cnt_3f      <= '0;
      cnt_fe      <= '0;
      first_byte  <= '0;
      fill_ok     <= 1'b0;
      ext_q       <= '0;
      mode_q      <= '0;
      force_bs    <= '0;
      sc          <= 1'b0;
      rom_size    <= '0;
      detect_done <= 1'b0;
    end else begin
      dl_q <= ioctl.ioctl_download;
      if (start || state == S_LOAD) begin
        cnt        <= cnt_n;
        sh         <= sh_n;
        cnt_e0     <= e0_n;
        cnt_3f     <= f3_n;
        cnt_fe     <= fe_n;
        first_byte <= first_n;
        fill_ok    <= fill_n;
      end
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state       <= S_LOAD;
          detect_done <= 1'b0;
          ext_q       <= file_ext;
          mode_q      <= sc_mode;
        end
        S_LOAD: if (fall) state <= S_DECIDE;
        S_DECIDE: begin
          force_bs    <= bs_dec;
          sc          <= sc_dec;
          rom_size    <= cnt;
          detect_done <= 1'b1;
          state       <= S_DONE;
        end
      endcase
    end
  end

endmodule
